// File: rtl/seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seg_scan_driver
//   Multiplexed 8-digit, 7-segment display scanner with a double-buffered
//   frame interface. One digit is driven per scan step; a frame offered by
//   the producer lands in a shadow buffer and is promoted to the displayed
//   buffer only at the 7->0 pointer wrap, so a frame never changes mid-scan.
//
//   Optional build macro: SEG_SCAN_LZ_BLANK_EN
//     defined   -> leading-zero blanking from digit 7 downward (digit 0 kept)
//     undefined -> zero nibbles display as "0"; blanking only via frame_en
//
// Parameters
//   F_CLK        system clock frequency in Hz
//   F_SCAN       digit-step rate in Hz (one frame = 8 steps)
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   frame_data   eight hex nibbles, digit k = bits [4k+3:4k]
//   frame_dp     decimal point per digit, 1 = lit
//   frame_en     digit enable, 0 = blank
//   frame_valid  producer offers a frame
//   frame_ready  frame can be accepted this cycle
//   cs           digit select, active-low one-hot
//   seg          segments, active-low {dp,g,f,e,d,c,b,a}
//   frame_done   one-cycle pulse, aligned with digit 0 of each new frame
// ---------------------------------------------------------------------------
module seg_scan_driver #(
  parameter int F_CLK  = 50000000,
  parameter int F_SCAN = 8000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] frame_data,
  input  logic [7:0]  frame_dp,
  input  logic [7:0]  frame_en,
  input  logic        frame_valid,
  output logic        frame_ready,
  output logic [7:0]  cs,
  output logic [7:0]  seg,
  output logic        frame_done
);

  localparam int DIV = F_CLK / F_SCAN;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(DIV - 1);

  logic [CW-1:0] tick_cnt;
  logic          tick;
  logic          wrap;
  logic          xfer;
  logic          load;
  logic [2:0]    ptr;
  logic [2:0]    ptr_next;
  logic          pending;
  logic          pending_next;

  logic [31:0]   shadow_data;
  logic [7:0]    shadow_dp;
  logic [7:0]    shadow_en;
  logic [31:0]   act_data;
  logic [7:0]    act_dp;
  logic [7:0]    act_en;
  logic [31:0]   act_data_next;
  logic [7:0]    act_dp_next;
  logic [7:0]    act_en_next;

  logic [7:0]    lz_mask;
  logic [3:0]    nib;
  logic [6:0]    glyph;
  logic [7:0]    seg_next;

  always_comb begin
    tick     = (tick_cnt == TC);
    wrap     = tick && (ptr == 3'd7);
    xfer     = frame_valid && frame_ready;
    load     = wrap && pending;
    ptr_next = tick ? ptr + 3'd1 : ptr;

    // A transfer can only happen while nothing is pending, so it never
    // collides with the promotion of an older frame at the same wrap.
    if (xfer)      pending_next = 1'b1;
    else if (wrap) pending_next = 1'b0;
    else           pending_next = pending;

    act_data_next = load ? shadow_data : act_data;
    act_dp_next   = load ? shadow_dp   : act_dp;
    act_en_next   = load ? shadow_en   : act_en;
  end

`ifdef SEG_SCAN_LZ_BLANK_EN
  logic leading;

  always_comb begin
    lz_mask = '0;
    leading = 1'b1;
    for (int k = 7; k >= 1; k--) begin
      if (leading && (act_data_next[4*k +: 4] == 4'h0) && !act_dp_next[k])
        lz_mask[k] = 1'b1;
      else
        leading = 1'b0;
    end
  end
`else
  always_comb begin
    lz_mask = '0;
  end
`endif

  // Decode from next-state values so cs and seg change on the same edge.
  always_comb begin
    nib = act_data_next[{ptr_next, 2'b00} +: 4];
    case (nib)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
    if (!act_en_next[ptr_next] || lz_mask[ptr_next])
      seg_next = 8'hFF;
    else
      seg_next = {~act_dp_next[ptr_next], glyph};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt    <= '0;
      ptr         <= 3'd0;
      pending     <= 1'b0;
      shadow_data <= '0;
      shadow_dp   <= '0;
      shadow_en   <= '0;
      act_data    <= '0;
      act_dp      <= '0;
      act_en      <= '0;
      cs          <= 8'hFF;
      seg         <= 8'hFF;
      frame_done  <= 1'b0;
      frame_ready <= 1'b0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      ptr      <= ptr_next;
      pending  <= pending_next;
      if (xfer) begin
        shadow_data <= frame_data;
        shadow_dp   <= frame_dp;
        shadow_en   <= frame_en;
      end
      act_data    <= act_data_next;
      act_dp      <= act_dp_next;
      act_en      <= act_en_next;
      cs          <= ~(8'b1 << ptr_next);
      seg         <= seg_next;
      frame_done  <= wrap;
      frame_ready <= ~pending_next;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_driver
//   Bench for seg_scan_driver at F_CLK=80, F_SCAN=8 (10 clocks per digit).
//   The reference tracks the number of clock edges since reset release and
//   derives digit, frame boundary and buffer promotion from that count.
// ---------------------------------------------------------------------------
module tb_seg_scan_driver;

  localparam int DIV   = 10;
  localparam int FRAME = 8 * DIV;

  localparam logic [7:0] HEX [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] frame_data;
  logic [7:0]  frame_dp;
  logic [7:0]  frame_en;
  logic        frame_valid;
  logic        frame_ready;
  logic [7:0]  cs;
  logic [7:0]  seg;
  logic        frame_done;

  always #5 clk = ~clk;

  seg_scan_driver #(.F_CLK(80), .F_SCAN(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_data  (frame_data),
    .frame_dp    (frame_dp),
    .frame_en    (frame_en),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .cs          (cs),
    .seg         (seg),
    .frame_done  (frame_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference state
  int          cyc;
  logic        m_pend;
  logic        m_ready;
  logic [31:0] sh_d, ac_d;
  logic [7:0]  sh_dp, sh_en, ac_dp, ac_en;
  logic [7:0]  exp_cs, exp_seg;
  logic        exp_done;

  typedef struct {
    logic [31:0]     data;
    logic [7:0]      dp;
    logic [7:0]      en;
    logic [7:0][7:0] exp;
  } vec_t;
  vec_t tbl[6];

  function automatic logic [7:0] exp_digit(input int k, input logic [31:0] d,
                                           input logic [7:0] dp, input logic [7:0] en);
    logic [3:0] n;
    logic [7:0] h;
    n = d[4*k +: 4];
    h = HEX[n];
    if (!en[k]) return 8'hFF;
`ifdef SEG_SCAN_LZ_BLANK_EN
    if (k > 0) begin
      bit blank;
      blank = 1'b1;
      for (int j = k; j <= 7; j++)
        if (d[4*j +: 4] != 4'h0 || dp[j]) blank = 1'b0;
      if (blank) return 8'hFF;
    end
`endif
    return {~dp[k], h[6:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t cyc=%0d: got %0h expected %0h", name, $time, cyc, act, exp);
    end
  endtask

  // One clock: advance the reference from the inputs present at the edge,
  // then compare all outputs 1 time unit later.
  task automatic step();
    int digit;
    @(posedge clk);
    if (rst) begin
      cyc = 0; m_pend = 0; m_ready = 0;
      sh_d = '0; sh_dp = '0; sh_en = '0;
      ac_d = '0; ac_dp = '0; ac_en = '0;
      exp_cs = 8'hFF; exp_seg = 8'hFF; exp_done = 0;
    end else begin
      bit xf;
      xf = frame_valid && m_ready;
      cyc++;
      exp_done = (cyc % FRAME == 0);
      if (exp_done && m_pend) begin
        ac_d = sh_d; ac_dp = sh_dp; ac_en = sh_en; m_pend = 0;
      end
      if (xf) begin
        sh_d = frame_data; sh_dp = frame_dp; sh_en = frame_en; m_pend = 1;
      end
      m_ready = !m_pend;
      digit   = (cyc / DIV) % 8;
      exp_cs  = ~(8'b1 << digit);
      exp_seg = exp_digit(digit, ac_d, ac_dp, ac_en);
    end
    #1;
    check("cs", cs, exp_cs);
    check("seg", seg, exp_seg);
    check("frame_done", frame_done, exp_done);
    check("frame_ready", frame_ready, m_ready);
  endtask

  task automatic step_until(input int phase);
    int n = 0;
    while ((cyc % FRAME) != phase && n < 2 * FRAME) begin
      step();
      n++;
    end
  endtask

  task automatic wait_wrap(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!frame_done && n < 2 * FRAME + 10);
    if (!frame_done) check("wrap_timeout", 0, 1);
  endtask

  task automatic send(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] en);
    int n = 0;
    while (!frame_ready && n < 2 * FRAME + 10) begin
      step();
      n++;
    end
    if (!frame_ready) check("ready_timeout", 0, 1);
    frame_data = d; frame_dp = dp; frame_en = en; frame_valid = 1;
    step();
    frame_valid = 0;
  endtask

  task automatic set_vec(input int i, input logic [31:0] d, input logic [7:0] dp,
                         input logic [7:0] en, input logic [63:0] e);
    tbl[i].data = d; tbl[i].dp = dp; tbl[i].en = en; tbl[i].exp = e;
  endtask

  initial begin
    int n;
    int pulses;
    logic [7:0] prev0;

    set_vec(0, 32'h76543210, 8'h01, 8'hFF, {8'hF8,8'h82,8'h92,8'h99,8'hB0,8'hA4,8'hF9,8'h40});
    set_vec(1, 32'hFEDCBA98, 8'h00, 8'hFF, {8'h8E,8'h86,8'hA1,8'hC6,8'h83,8'h88,8'h90,8'h80});
`ifdef SEG_SCAN_LZ_BLANK_EN
    set_vec(2, 32'h00000305, 8'h00, 8'hFF, {8'hFF,8'hFF,8'hFF,8'hFF,8'hFF,8'hB0,8'hC0,8'h92});
    set_vec(5, 32'h00000000, 8'h00, 8'hFF, {8'hFF,8'hFF,8'hFF,8'hFF,8'hFF,8'hFF,8'hFF,8'hC0});
`else
    set_vec(2, 32'h00000305, 8'h00, 8'hFF, {8'hC0,8'hC0,8'hC0,8'hC0,8'hC0,8'hB0,8'hC0,8'h92});
    set_vec(5, 32'h00000000, 8'h00, 8'hFF, {8'hC0,8'hC0,8'hC0,8'hC0,8'hC0,8'hC0,8'hC0,8'hC0});
`endif
    set_vec(3, 32'h12345678, 8'hF0, 8'h0F, {8'hFF,8'hFF,8'hFF,8'hFF,8'h92,8'h82,8'hF8,8'h80});
    set_vec(4, 32'h00000000, 8'h80, 8'hFF, {8'h40,8'hC0,8'hC0,8'hC0,8'hC0,8'hC0,8'hC0,8'hC0});

    frame_data = '0; frame_dp = '0; frame_en = '0; frame_valid = 0;
    cyc = 0; m_pend = 0; m_ready = 0;

    // reset state
    rst = 1;
    repeat (3) step();
    check("reset_cs", cs, 8'hFF);
    check("reset_seg", seg, 8'hFF);
    check("reset_ready", frame_ready, 0);
    rst = 0;
    step();
    check("release_ready", frame_ready, 1);
    check("release_cs", cs, 8'hFE);

    // idle scan: blank display, a frame_done every 80 clocks
    pulses = 0;
    for (int i = 0; i < 2 * FRAME - 1; i++) begin
      step();
      if (frame_done) pulses++;
    end
    check("idle_done_pulses", pulses, 2);

    // table of frames, each sent mid-frame and checked digit by digit
    for (int v = 0; v < 6; v++) begin
      step_until(30 + 3 * v);
      send(tbl[v].data, tbl[v].dp, tbl[v].en);
      check("ready_drop", frame_ready, 0);
      wait_wrap(n);
      check("ready_after_wrap", frame_ready, 1);
      for (int i = 0; i < FRAME; i++) begin
        step();
        if (cyc % DIV == 5)
          check($sformatf("vec%0d_digit%0d", v, (cyc / DIV) % 8), seg, tbl[v].exp[(cyc / DIV) % 8]);
      end
    end

    // transfer on the wrap-tick cycle lands one frame later
    step_until(FRAME - 1);
    prev0 = exp_digit(0, ac_d, ac_dp, ac_en);
    frame_data = 32'h00000008; frame_dp = 8'h00; frame_en = 8'hFF; frame_valid = 1;
    step();
    frame_valid = 0;
    check("wrap_xfer_done", frame_done, 1);
    check("wrap_xfer_not_applied", seg, prev0);
    check("wrap_xfer_ready", frame_ready, 0);
    wait_wrap(n);
    check("wrap_xfer_applied", seg, 8'h80);

    // second offer while pending is ignored
    step_until(20);
    send(32'h11111111, 8'h00, 8'hFF);
    frame_data = 32'h22222222; frame_valid = 1;
    repeat (5) step();
    frame_valid = 0;
    wait_wrap(n);
    check("pending_first_kept", seg, 8'hF9);
    repeat (15) step();
    check("pending_first_kept_d1", seg, 8'hF9);

    // reset at pointer 5 with a pending frame
    step_until(20);
    send(32'h99999999, 8'h00, 8'hFF);
    step_until(55);
    check("ptr5_cs", cs, 8'hDF);
    rst = 1;
    step();
    check("midrst_cs", cs, 8'hFF);
    check("midrst_seg", seg, 8'hFF);
    check("midrst_ready", frame_ready, 0);
    rst = 0;
    step();
    check("midrst_restart_cs", cs, 8'hFE);
    wait_wrap(n);
    check("midrst_first_wrap", n, FRAME - 1);
    check("midrst_discarded", seg, 8'hFF);

    // randomized traffic with occasional resets
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 399) == 0);
      frame_valid = ($urandom_range(0, 3) == 0);
      frame_data  = $urandom >> (4 * $urandom_range(0, 7));
      frame_dp    = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      frame_en    = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF;
      step();
    end
    rst = 0; frame_valid = 0;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter F_CLK, default 50000000, system clock frequency in Hz.
REQ-002 Parameter F_SCAN, default 8000, digit-step rate in Hz; one 8-digit frame lasts 8 steps.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 frame_data  input  32  eight hex nibbles; digit k = bits [4k+3:4k].
REQ-006 frame_dp  input  8  decimal point per digit; bit k = digit k, 1 = lit.
REQ-007 frame_en  input  8  digit enable; bit k = 0 blanks digit k.
REQ-008 frame_valid  input  1  producer offers a new frame.
REQ-009 frame_ready  output  1  block can accept a frame this cycle.
REQ-010 cs  output  8  digit select, active-low one-hot; bit k = digit k.
REQ-011 seg  output  8  segments, active-low, {dp,g,f,e,d,c,b,a}.
REQ-012 frame_done  output  1  one-cycle pulse at frame end.

Function
REQ-013 Tick counter SHALL count 0..DIV-1, DIV = F_CLK/F_SCAN (integer division), emitting a one-cycle tick on reaching DIV-1, then wrapping to 0.
REQ-014 Digit pointer (3 bits) SHALL advance 0->1->...->7->0 on each tick.
REQ-015 On the cycle after a tick, cs SHALL drive the new pointer's digit low, all other bits high; seg SHALL update on the same edge (outputs registered, latency 1 clock from tick).
REQ-016 seg SHALL be the hex decode 0-F of the selected active nibble, standard segment patterns (0=0xC0, 1=0xF9, 8=0x80, F=0x8E with dp off), dp bit driven from active dp bit.
REQ-017 Disabled digit (active en bit 0) SHALL output seg = 0xFF while its cs bit is still driven low.
REQ-018 Handshake: transfer occurs on a cycle with frame_valid=1 and frame_ready=1; data, dp, en captured into a shadow buffer and pending flag set.
REQ-019 frame_ready SHALL equal NOT pending (registered, so it drops the cycle after a transfer).
REQ-020 On the tick that wraps pointer 7->0, if pending, shadow SHALL copy to active buffer and pending clear; frames never change mid-scan.
REQ-021 Transfer coinciding with the 7->0 wrap tick SHALL land in shadow and be applied at the following wrap, not the current one.
REQ-022 frame_done SHALL pulse high for exactly the one cycle after each 7->0 wrap tick, aligned with cs = 0xFE.
REQ-023 frame_valid while frame_ready=0 SHALL be ignored; producer holds data until accepted.

Reset
REQ-024 While rst=1: tick counter 0, pointer 0, pending 0, shadow and active buffers 0 with en=0, cs=0xFF, seg=0xFF, frame_done=0, frame_ready=0.
REQ-025 frame_ready SHALL go 1 on the first clock after rst deasserts; first tick arrives DIV cycles after deassertion, driving digit 1.
REQ-026 rst asserted mid-frame or with a pending frame SHALL discard the pending frame and apply REQ-024 on the next edge.

Configuration
REQ-027 Macro SEG_SCAN_LZ_BLANK_EN: when defined, leading-zero blanking SHALL apply — scanning from digit 7 downward, each digit with nibble 0 and dp 0 is blanked (seg=0xFF) until the first nonzero nibble or lit dp; digit 0 is never blanked by this rule.
REQ-028 Without SEG_SCAN_LZ_BLANK_EN, zero nibbles SHALL display as 0xC0; blanking only via frame_en.

Verification (F_CLK=80, F_SCAN=8, DIV=10)
REQ-029 Reset released, no frame -> cs cycles 0xFE..0x7F every 10 clocks, seg=0xFF throughout, frame_done pulses every 80 clocks.
REQ-030 Send data=0x76543210, dp=0x01, en=0xFF mid-frame -> ready drops next cycle; display unchanged until wrap; then digit 0 seg=0x40, digit 3 seg=0xB0, digit 7 seg=0xF8; ready returns high after wrap.
REQ-031 Assert valid on the wrap-tick cycle with data=0x00000008 -> applied one frame later, not current one.
REQ-032 Second valid while pending -> ignored; only first frame displayed.
REQ-033 With SEG_SCAN_LZ_BLANK_EN, data=0x00000305, dp=0, en=0xFF -> digits 7..3 seg=0xFF, digit 2=0xB0, digit 1=0xC0, digit 0=0x92; without the macro digits 7..3 show 0xC0.
REQ-034 Assert rst for one cycle at pointer 5 with pending frame -> cs=0xFF, seg=0xFF, pending cleared, restart at digit 0 timing.
